// File: rtl/regfile_write_arbiter_if.sv
// Bundle of requester handshakes and register-file write port for the write arbiter.
// Requesters and the register file sit on the master side; the arbiter uses the slave side.
interface regfile_write_arbiter_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
);
  logic              hold;
  logic              aValid;
  logic [ADDR_W-1:0] aAddr;
  logic [DATA_W-1:0] aData;
  logic              aReady;
  logic              bValid;
  logic [ADDR_W-1:0] bAddr;
  logic [DATA_W-1:0] bData;
  logic              bReady;
  logic [DATA_W-1:0] regIn;
  logic [ADDR_W-1:0] regInAddr;
  logic              regInWE;
  logic              prio;
  logic [7:0]        aCount;
  logic [7:0]        bCount;

  modport slave (
    input  hold, aValid, aAddr, aData, bValid, bAddr, bData,
    output aReady, bReady, regIn, regInAddr, regInWE, prio, aCount, bCount
  );

  modport master (
    output hold, aValid, aAddr, aData, bValid, bAddr, bData,
    input  aReady, bReady, regIn, regInAddr, regInWE, prio, aCount, bCount
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two-requester round-robin arbiter for a single register-file write port.
// Grants are combinational; the winning write is registered and presented one cycle later.
module regfile_write_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
) (
  input logic                    clk,
  input logic                    rst,
  regfile_write_arbiter_if.slave bus
);

  logic              a_grant, b_grant;
  logic              prio_q, prio_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        a_cnt_q, a_cnt_d;
  logic [7:0]        b_cnt_q, b_cnt_d;

  // Ready is gated by rst as well so nothing is granted while reset is asserted.
  always_comb begin
    a_grant = 1'b0;
    b_grant = 1'b0;
    if (rst && !bus.hold) begin
      if (bus.aValid && (!bus.bValid || !prio_q)) begin
        a_grant = 1'b1;
      end else if (bus.bValid) begin
        b_grant = 1'b1;
      end
    end
  end

  always_comb begin
    prio_d  = prio_q;
    we_d    = 1'b0;
    data_d  = data_q;
    addr_d  = addr_q;
    a_cnt_d = a_cnt_q;
    b_cnt_d = b_cnt_q;
    if (a_grant) begin
      prio_d = 1'b1;
      we_d   = 1'b1;
      data_d = bus.aData;
      addr_d = bus.aAddr;
      if (a_cnt_q != 8'hff) begin
        a_cnt_d = a_cnt_q + 8'd1;
      end
    end else if (b_grant) begin
      prio_d = 1'b0;
      we_d   = 1'b1;
      data_d = bus.bData;
      addr_d = bus.bAddr;
      if (b_cnt_q != 8'hff) begin
        b_cnt_d = b_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q  <= 1'b0;
      we_q    <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      a_cnt_q <= 8'd0;
      b_cnt_q <= 8'd0;
    end else begin
      prio_q  <= prio_d;
      we_q    <= we_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
    end
  end

  assign bus.aReady    = a_grant;
  assign bus.bReady    = b_grant;
  assign bus.regIn     = data_q;
  assign bus.regInAddr = addr_q;
  assign bus.regInWE   = we_q;
  assign bus.prio      = prio_q;
  assign bus.aCount    = a_cnt_q;
  assign bus.bCount    = b_cnt_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: the driver queues each expected register write,
// and a negedge monitor pops and compares whenever regInWE is high.
module tb_regfile_write_arbiter;

  typedef struct packed {
    logic [2:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   a_model;
  wr_t  exp_q[$];
  wr_t  mon_e;

  regfile_write_arbiter_if #(.DATA_W(16), .ADDR_W(3)) bus ();

  regfile_write_arbiter #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive(input logic h, input logic av, input logic [2:0] aa, input logic [15:0] ad,
                       input logic bv, input logic [2:0] ba, input logic [15:0] bd);
    bus.hold   = h;
    bus.aValid = av;
    bus.aAddr  = aa;
    bus.aData  = ad;
    bus.bValid = bv;
    bus.bAddr  = ba;
    bus.bData  = bd;
  endtask

  task automatic push_wr(input logic [2:0] a, input logic [15:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst && bus.regInWE) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h, required no write at %0t",
                 bus.regInAddr, bus.regIn, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_addr", 32'(bus.regInAddr), 32'(mon_e.addr));
        chk("write_data", 32'(bus.regIn), 32'(mon_e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with both requesters asserting valid.
    drive(1'b0, 1'b1, 3'd1, 16'h1234, 1'b1, 3'd2, 16'h5678);
    @(negedge clk);
    chk("rst_aReady", 32'(bus.aReady), 0);
    chk("rst_bReady", 32'(bus.bReady), 0);
    chk("rst_we", 32'(bus.regInWE), 0);
    chk("rst_regIn", 32'(bus.regIn), 0);
    chk("rst_prio", 32'(bus.prio), 0);
    chk("rst_aCount", 32'(bus.aCount), 0);
    chk("rst_bCount", 32'(bus.bCount), 0);
    next_cycle();
    rst = 1'b1;

    // Single A transfer.
    drive(1'b0, 1'b1, 3'b010, 16'hbbbb, 1'b0, 3'd0, 16'h0);
    push_wr(3'b010, 16'hbbbb);
    @(negedge clk);
    chk("single_aReady", 32'(bus.aReady), 1);
    chk("single_bReady", 32'(bus.bReady), 0);
    next_cycle();
    drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    @(negedge clk);
    chk("single_we", 32'(bus.regInWE), 1);
    chk("single_aCount", 32'(bus.aCount), 1);
    chk("single_prio", 32'(bus.prio), 1);
    next_cycle();
    @(negedge clk);
    chk("idle_we", 32'(bus.regInWE), 0);
    chk("idle_regIn_hold", 32'(bus.regIn), 32'hbbbb);
    chk("idle_addr_hold", 32'(bus.regInAddr), 32'h2);
    next_cycle();

    // Single B transfer returns prio to A.
    drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 16'h1234);
    push_wr(3'd5, 16'h1234);
    @(negedge clk);
    chk("singleb_bReady", 32'(bus.bReady), 1);
    chk("singleb_aReady", 32'(bus.aReady), 0);
    next_cycle();

    // Contention: alternating grants A,B,A,B with continuous WE.
    drive(1'b0, 1'b1, 3'd0, 16'hffff, 1'b1, 3'd1, 16'haaaa);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) push_wr(3'd0, 16'hffff);
      else            push_wr(3'd1, 16'haaaa);
      @(negedge clk);
      chk("cont_prio", 32'(bus.prio), (k % 2 == 0) ? 0 : 1);
      chk("cont_aReady", 32'(bus.aReady), (k % 2 == 0) ? 1 : 0);
      chk("cont_bReady", 32'(bus.bReady), (k % 2 == 0) ? 0 : 1);
      chk("cont_we", 32'(bus.regInWE), 1);
      next_cycle();
    end
    drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    @(negedge clk);
    chk("cont_we_last", 32'(bus.regInWE), 1);
    chk("cont_aCount", 32'(bus.aCount), 3);
    chk("cont_bCount", 32'(bus.bCount), 3);
    chk("cont_prio_end", 32'(bus.prio), 0);
    next_cycle();

    // Same address: winner first, loser the next cycle.
    drive(1'b0, 1'b1, 3'b011, 16'h1111, 1'b1, 3'b011, 16'h5555);
    push_wr(3'b011, 16'h1111);
    @(negedge clk);
    chk("same_aReady", 32'(bus.aReady), 1);
    chk("same_bReady0", 32'(bus.bReady), 0);
    next_cycle();
    drive(1'b0, 1'b0, 3'b011, 16'h1111, 1'b1, 3'b011, 16'h5555);
    push_wr(3'b011, 16'h5555);
    @(negedge clk);
    chk("same_bReady1", 32'(bus.bReady), 1);
    next_cycle();
    drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    @(negedge clk);
    chk("same_prio", 32'(bus.prio), 0);
    chk("same_aCount", 32'(bus.aCount), 4);
    chk("same_bCount", 32'(bus.bCount), 4);
    next_cycle();

    // Hold: a pending write still fires, nothing granted, state frozen.
    drive(1'b0, 1'b1, 3'd6, 16'h6666, 1'b0, 3'd0, 16'h0);
    push_wr(3'd6, 16'h6666);
    @(negedge clk);
    chk("prehold_aReady", 32'(bus.aReady), 1);
    next_cycle();
    drive(1'b1, 1'b1, 3'd7, 16'h7777, 1'b1, 3'd4, 16'h4444);
    for (int h = 0; h < 4; h++) begin
      @(negedge clk);
      chk("hold_aReady", 32'(bus.aReady), 0);
      chk("hold_bReady", 32'(bus.bReady), 0);
      chk("hold_we", 32'(bus.regInWE), (h == 0) ? 1 : 0);
      chk("hold_prio", 32'(bus.prio), 1);
      chk("hold_aCount", 32'(bus.aCount), 5);
      chk("hold_bCount", 32'(bus.bCount), 4);
      next_cycle();
    end
    drive(1'b0, 1'b1, 3'd7, 16'h7777, 1'b1, 3'd4, 16'h4444);
    push_wr(3'd4, 16'h4444);
    @(negedge clk);
    chk("release_bReady", 32'(bus.bReady), 1);
    chk("release_aReady", 32'(bus.aReady), 0);
    next_cycle();
    drive(1'b0, 1'b1, 3'd7, 16'h7777, 1'b0, 3'd0, 16'h0);
    push_wr(3'd7, 16'h7777);
    @(negedge clk);
    chk("release_aReady2", 32'(bus.aReady), 1);
    next_cycle();
    drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    @(negedge clk);
    chk("release_aCount", 32'(bus.aCount), 6);
    chk("release_bCount", 32'(bus.bCount), 5);
    chk("release_prio", 32'(bus.prio), 1);
    next_cycle();

    // Reset mid-operation discards the registered write.
    drive(1'b0, 1'b1, 3'd2, 16'hdead, 1'b0, 3'd0, 16'h0);
    @(negedge clk);
    chk("mid_aReady", 32'(bus.aReady), 1);
    next_cycle();
    drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    chk("mid_we_before", 32'(bus.regInWE), 1);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_we", 32'(bus.regInWE), 0);
    chk("mid_regIn", 32'(bus.regIn), 0);
    chk("mid_addr", 32'(bus.regInAddr), 0);
    chk("mid_prio", 32'(bus.prio), 0);
    chk("mid_aCount", 32'(bus.aCount), 0);
    chk("mid_bCount", 32'(bus.bCount), 0);
    drive(1'b0, 1'b1, 3'd1, 16'h1, 1'b1, 3'd2, 16'h2);
    #1;
    chk("inrst_aReady", 32'(bus.aReady), 0);
    chk("inrst_bReady", 32'(bus.bReady), 0);
    next_cycle();
    rst = 1'b1;

    // Saturation: 300 back-to-back A writes, granted from the first cycle after reset.
    a_model = 0;
    for (int i = 0; i < 300; i++) begin
      drive(1'b0, 1'b1, 3'(i), 16'(i * 7), 1'b0, 3'd0, 16'h0);
      push_wr(3'(i), 16'(i * 7));
      @(negedge clk);
      if (i == 0) chk("sat_first_aReady", 32'(bus.aReady), 1);
      chk("sat_aCount", 32'(bus.aCount), 32'(a_model));
      if (a_model < 255) a_model++;
      next_cycle();
    end
    drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    @(negedge clk);
    chk("sat_final_aCount", 32'(bus.aCount), 255);
    chk("sat_final_bCount", 32'(bus.bCount), 0);
    next_cycle();
    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter DATA_W, 16, data width of the register-file write port.
REQ-002 Parameter ADDR_W, 3, register address width (8 registers).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 hold  input  1  when high, no request is granted.
REQ-006 aValid  input  1  requester A has a pending write.
REQ-007 aAddr  input  ADDR_W  target register of requester A.
REQ-008 aData  input  DATA_W  write data of requester A.
REQ-009 aReady  output  1  requester A write accepted this cycle.
REQ-010 bValid, bAddr, bData, bReady  same widths and meaning as REQ-006..009, for requester B.
REQ-011 regIn  output  DATA_W  write data to the register file.
REQ-012 regInAddr  output  ADDR_W  write address to the register file.
REQ-013 regInWE  output  1  write enable to the register file.
REQ-014 prio  output  1  current priority pointer; 0 = A preferred, 1 = B preferred.
REQ-015 aCount, bCount  output  8 each  saturating count of accepted writes per requester.

Function
REQ-016 Transfer SHALL occur on a requester when its valid and ready are both high at a rising clk edge.
REQ-017 aReady and bReady SHALL be combinational and SHALL never both be high.
REQ-018 hold high SHALL force aReady=bReady=0 regardless of valid inputs.
REQ-019 Only A valid (hold low): aReady=1; only B valid: bReady=1; neither valid: both 0.
REQ-020 Both valid: grant SHALL go to A if prio=0, to B if prio=1.
REQ-021 After any transfer, prio SHALL be set to point at the requester that was not granted; prio unchanged in cycles without a transfer.
REQ-022 On a transfer, regIn/regInAddr SHALL register the granted data/address and regInWE SHALL be 1 in the following cycle (latency 1 clk from acceptance to WE).
REQ-023 In any cycle following a non-transfer cycle, regInWE SHALL be 0 and regIn/regInAddr SHALL hold their last values.
REQ-024 Back-to-back transfers SHALL produce regInWE high on consecutive cycles; sustained throughput one write per clk.
REQ-025 Both requesters valid with the same address: the winner writes first, the loser is granted in the next cycle, so the loser's data is the final register content.
REQ-026 A requester SHALL hold valid, addr and data stable until accepted; the arbiter SHALL not buffer ungranted requests.
REQ-027 aCount/bCount SHALL increment by 1 on each transfer of the respective requester and saturate at 255 (no wrap).
REQ-028 hold asserted SHALL not alter prio, counters or the pending output write already registered (its regInWE still fires).

Reset
REQ-029 rst low SHALL immediately (asynchronously) force regInWE=0, regIn=0, regInAddr=0, prio=0, aCount=0, bCount=0.
REQ-030 While rst is low, aReady and bReady SHALL be 0.
REQ-031 rst asserted mid-operation SHALL discard a registered but not yet performed write (regInWE drops without a write); first grant possible in the first cycle after rst deasserts.

Verification
REQ-032 Reset: rst low, aValid=bValid=1 -> aReady=bReady=0, regInWE=0, prio=0, counters 0.
REQ-033 Single: aValid=1, aAddr=3'b010, aData=16'hbbbb for one transfer -> next cycle regInWE=1, regInAddr=3'b010, regIn=16'hbbbb, aCount=1, prio=1.
REQ-034 Contention: aValid=bValid=1 held, A addr 0 data 16'hffff, B addr 1 data 16'haaaa, prio=0 -> grants A,B,A,B on consecutive cycles, regInWE continuously 1.
REQ-035 Same address: A and B both target 3'b011, A=16'h1111, B=16'h5555, prio=0 -> writes 16'h1111 then 16'h5555 on consecutive cycles.
REQ-036 Hold: hold=1 with both valid for 4 cycles -> no ready, regInWE=0 after the first cycle, prio and counters unchanged; hold=0 -> grant per prio.
REQ-037 Saturation: 300 back-to-back A transfers -> aCount stops at 255, bCount=0.
